decode_wb_pipe: RTL
===================

// Module: decode_wb_pipe
// PURPOSE
//  Parametrised Y86-64 decode/writeback stage with a registered D->E pipeline register.
//  Decodes src/dst IDs, reads a resettable register file and forwards from e/M/W.
//  Flags load-use hazards and drives the E-stage register under stall/bubble control.
//  Sits between the fetch pipe register (D_*) and the execute stage (E_*).
// PARAMETERS
//  XLEN    64  datapath width of register, valC and valP values
//  NREG    15  number of architectural registers; IDs >= NREG read 0 and are never written
//  RIDX    4   register ID width; all-ones ID (NONE) means no register
//  STAT_W  2   status width; value 0 = AOK
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high
//  D_stat       in   STAT_W  fetch status
//  D_icode      in   4       opcode
//  D_ifun       in   4       function code
//  D_rA, D_rB   in   RIDX    register IDs
//  D_valC       in   XLEN    constant
//  D_valP       in   XLEN    next PC
//  e_dstE/e_valE   in  RIDX/XLEN  execute-stage forward source
//  M_dstE/M_valE   in  RIDX/XLEN  memory-stage ALU result
//  M_dstM/m_valM   in  RIDX/XLEN  memory-stage load data
//  W_stat       in   STAT_W  writeback status
//  W_dstE/W_valE   in  RIDX/XLEN  writeback ALU result
//  W_dstM/W_valM   in  RIDX/XLEN  writeback load data
//  E_stall      in   1       hold the E register
//  E_bubble     in   1       load a NOP into the E register
//  dbg_idx      in   RIDX    debug read index
//  dbg_val      out  XLEN    registers[dbg_idx], or 0 if dbg_idx >= NREG
//  load_use     out  1       combinational load-use hazard flag
//  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB
//               out  (widths as D_*)  registered E-stage fields
// BEHAVIOUR
//  Decode (combinational), NONE = all-ones ID, rsp = 4:
//   - halt, nop, jXX: all IDs NONE.
//   - cmov, OPq: srcA=rA, srcB=rB, dstE=rB.
//   - irmovq: srcB=dstE=rB.
//   - rmmovq: srcA=rA, srcB=rB.
//   - mrmovq: srcB=rB, dstM=rA.
//   - call: srcB=dstE=rsp.
//   - ret: srcA=srcB=dstE=rsp.
//   - push: srcA=rA, srcB=dstE=rsp.
//   - pop: srcA=srcB=dstE=rsp, dstM=rA.
//   - Illegal icode: all IDs NONE.
//  Operand select, per src, first match wins:
//   - valA only: if icode is call or jXX, valA = D_valP.
//   - src==NONE -> 0.
//   - Then e_dstE, M_dstM, M_dstE, W_dstM, W_dstE.
//   - Otherwise the register-file read.
//   - A forward source whose ID is NONE never matches.
//  load_use = (E_icode is mrmovq or pop) && E_dstM != NONE && E_dstM matches d_srcA or d_srcB.
//   The block does not act on it; hazard control drives E_bubble.
//  E register update on posedge clk, in priority order:
//   - reset: E_icode=1 (nop); E_stat, E_ifun, E_valC, E_valA, E_valB = 0; all E IDs = NONE.
//   - E_bubble: same values as reset.
//   - E_stall: all E_* hold.
//   - otherwise: load the decoded values (latency 1).
//  Register file:
//   - reset: all NREG entries cleared to 0.
//   - Otherwise, on posedge with W_stat==0: write W_valE to W_dstE, then W_valM to W_dstM.
//   - If both IDs are equal, W_valM wins.
//   - IDs NONE or >= NREG are ignored.
//   - W_stat != 0 blocks both writes.
//   - A write is visible to decode only after the edge; same-cycle values come via W forwarding.
//   - reset overrides a write in the same cycle.
// TESTING
//  - reset for 1 cycle -> E_icode=1, E IDs=NONE, dbg_val=0 for every index.
//  - W_dstE=2, W_valE=0x55, W_stat=0, one edge -> dbg_idx=2 gives 0x55.
//    Repeat with W_stat=1 and value 0x66 -> still 0x55.
//  - D = OPq rA=2 rB=3, e_dstE=2/e_valE=7, M_dstE=2/M_valE=9 -> next edge E_valA=7 (e beats M).
//  - E holds mrmovq with E_dstM=5, D = OPq rA=5 -> load_use=1.
//    Same case with E_dstM=NONE -> load_use=0.
//  - E_stall=1 for 2 cycles -> E_* unchanged.
//    E_stall=1 with E_bubble=1 -> E_icode=1, E_dstE=NONE.
//  - W_dstE=W_dstM=6, W_valE=1, W_valM=2 -> reg6=2.
//    call with D_valP=0x40 -> E_valA=0x40, E_dstE=4.

Source files
------------

// File: rtl/decode_wb_pipe.sv
// ---------------------------------------------------------------------------
// decode_wb_pipe
// Y86-64 decode / writeback stage with the registered D->E pipeline register.
//
// Purpose:
//   Turns the fetched instruction (D_*) into source/destination register IDs,
//   reads the register file, selects operands with forwarding from the
//   execute, memory and writeback stages, and loads the E-stage register
//   under stall/bubble control. Writeback results (W_*) are committed into
//   the register file on the rising edge. A combinational load-use flag is
//   raised for the hazard controller.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   D_stat/icode/ifun       fetch-stage status and instruction codes
//   D_rA, D_rB              fetched register IDs
//   D_valC, D_valP          fetched constant and next PC
//   e_dstE/e_valE           execute-stage forward source
//   M_dstE/M_valE           memory-stage ALU result forward source
//   M_dstM/m_valM           memory-stage load data forward source
//   W_stat                  writeback status (0 = AOK enables writes)
//   W_dstE/W_valE           writeback ALU result (forward + register write)
//   W_dstM/W_valM           writeback load data (forward + register write)
//   E_stall, E_bubble       E register hold / NOP injection
//   dbg_idx, dbg_val        debug read port into the register file
//   load_use                load-use hazard flag
//   E_*                     registered E-stage fields
// ---------------------------------------------------------------------------
module decode_wb_pipe #(
    parameter int XLEN   = 64,
    parameter int NREG   = 15,
    parameter int RIDX   = 4,
    parameter int STAT_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [STAT_W-1:0] D_stat,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        D_ifun,
    input  logic [RIDX-1:0]   D_rA,
    input  logic [RIDX-1:0]   D_rB,
    input  logic [XLEN-1:0]   D_valC,
    input  logic [XLEN-1:0]   D_valP,
    input  logic [RIDX-1:0]   e_dstE,
    input  logic [XLEN-1:0]   e_valE,
    input  logic [RIDX-1:0]   M_dstE,
    input  logic [XLEN-1:0]   M_valE,
    input  logic [RIDX-1:0]   M_dstM,
    input  logic [XLEN-1:0]   m_valM,
    input  logic [STAT_W-1:0] W_stat,
    input  logic [RIDX-1:0]   W_dstE,
    input  logic [XLEN-1:0]   W_valE,
    input  logic [RIDX-1:0]   W_dstM,
    input  logic [XLEN-1:0]   W_valM,
    input  logic              E_stall,
    input  logic              E_bubble,
    input  logic [RIDX-1:0]   dbg_idx,
    output logic [XLEN-1:0]   dbg_val,
    output logic              load_use,
    output logic [STAT_W-1:0] E_stat,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [XLEN-1:0]   E_valC,
    output logic [XLEN-1:0]   E_valA,
    output logic [XLEN-1:0]   E_valB,
    output logic [RIDX-1:0]   E_dstE,
    output logic [RIDX-1:0]   E_dstM,
    output logic [RIDX-1:0]   E_srcA,
    output logic [RIDX-1:0]   E_srcB
);

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_CMOV   = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_t;

    localparam logic [RIDX-1:0] RNONE   = '1;
    localparam logic [RIDX-1:0] RRSP    = RIDX'(4);
    localparam logic [RIDX:0]   NREG_EX = (RIDX+1)'(NREG);

    logic [XLEN-1:0]   r_regs [NREG];

    logic [STAT_W-1:0] r_stat;
    logic [3:0]        r_icode;
    logic [3:0]        r_ifun;
    logic [XLEN-1:0]   r_valC;
    logic [XLEN-1:0]   r_valA;
    logic [XLEN-1:0]   r_valB;
    logic [RIDX-1:0]   r_dstE;
    logic [RIDX-1:0]   r_dstM;
    logic [RIDX-1:0]   r_srcA;
    logic [RIDX-1:0]   r_srcB;

    logic [RIDX-1:0]   w_srcA;
    logic [RIDX-1:0]   w_srcB;
    logic [RIDX-1:0]   w_dstE;
    logic [RIDX-1:0]   w_dstM;
    logic [XLEN-1:0]   w_rfA;
    logic [XLEN-1:0]   w_rfB;
    logic [XLEN-1:0]   w_valA;
    logic [XLEN-1:0]   w_valB;

    // IDs at or above NREG (including NONE) have no storage behind them.
    function automatic logic inRange(input logic [RIDX-1:0] id);
        return ({1'b0, id} < NREG_EX);
    endfunction

    // A forward source tagged NONE must never match, even against a NONE src.
    function automatic logic hits(input logic [RIDX-1:0] src, input logic [RIDX-1:0] id);
        return (id != RNONE) && (id == src);
    endfunction

    // Source/destination ID decode; anything not listed uses no registers.
    always_comb begin
        w_srcA = RNONE;
        w_srcB = RNONE;
        w_dstE = RNONE;
        w_dstM = RNONE;
        case (D_icode)
            I_CMOV, I_OPQ: begin
                w_srcA = D_rA;
                w_srcB = D_rB;
                w_dstE = D_rB;
            end
            I_IRMOVQ: begin
                w_srcB = D_rB;
                w_dstE = D_rB;
            end
            I_RMMOVQ: begin
                w_srcA = D_rA;
                w_srcB = D_rB;
            end
            I_MRMOVQ: begin
                w_srcB = D_rB;
                w_dstM = D_rA;
            end
            I_CALL: begin
                w_srcB = RRSP;
                w_dstE = RRSP;
            end
            I_RET: begin
                w_srcA = RRSP;
                w_srcB = RRSP;
                w_dstE = RRSP;
            end
            I_PUSHQ: begin
                w_srcA = D_rA;
                w_srcB = RRSP;
                w_dstE = RRSP;
            end
            I_POPQ: begin
                w_srcA = RRSP;
                w_srcB = RRSP;
                w_dstE = RRSP;
                w_dstM = D_rA;
            end
            default: begin
                w_srcA = RNONE;
                w_srcB = RNONE;
                w_dstE = RNONE;
                w_dstM = RNONE;
            end
        endcase
    end

    assign w_rfA   = inRange(w_srcA)  ? r_regs[w_srcA]  : '0;
    assign w_rfB   = inRange(w_srcB)  ? r_regs[w_srcB]  : '0;
    assign dbg_val = inRange(dbg_idx) ? r_regs[dbg_idx] : '0;

    // Operand selection: youngest in-flight producer wins; call/jXX carry
    // valP through valA so later stages can push or fall through with it.
    always_comb begin
        w_valA = w_rfA;
        if (D_icode == I_CALL || D_icode == I_JXX) w_valA = D_valP;
        else if (w_srcA == RNONE)                  w_valA = '0;
        else if (hits(w_srcA, e_dstE))             w_valA = e_valE;
        else if (hits(w_srcA, M_dstM))             w_valA = m_valM;
        else if (hits(w_srcA, M_dstE))             w_valA = M_valE;
        else if (hits(w_srcA, W_dstM))             w_valA = W_valM;
        else if (hits(w_srcA, W_dstE))             w_valA = W_valE;

        w_valB = w_rfB;
        if (w_srcB == RNONE)                       w_valB = '0;
        else if (hits(w_srcB, e_dstE))             w_valB = e_valE;
        else if (hits(w_srcB, M_dstM))             w_valB = m_valM;
        else if (hits(w_srcB, M_dstE))             w_valB = M_valE;
        else if (hits(w_srcB, W_dstM))             w_valB = W_valM;
        else if (hits(w_srcB, W_dstE))             w_valB = W_valE;
    end

    // A load sitting in E cannot forward its data yet, so a reader in D
    // must wait; only the flag is produced here.
    assign load_use = (r_icode == I_MRMOVQ || r_icode == I_POPQ) &&
                      (r_dstM != RNONE) &&
                      (r_dstM == w_srcA || r_dstM == w_srcB);

    // Register file writeback; the valM write is placed second so it wins
    // when both ports target the same register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (W_stat == '0) begin
            for (int i = 0; i < NREG; i++) begin
                if (W_dstE != RNONE && W_dstE == RIDX'(i)) r_regs[i] <= W_valE;
                if (W_dstM != RNONE && W_dstM == RIDX'(i)) r_regs[i] <= W_valM;
            end
        end
    end

    // E pipeline register: reset and bubble both inject a NOP, stall holds.
    always_ff @(posedge clk) begin
        if (reset || E_bubble) begin
            r_stat  <= '0;
            r_icode <= I_NOP;
            r_ifun  <= '0;
            r_valC  <= '0;
            r_valA  <= '0;
            r_valB  <= '0;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
            r_srcA  <= RNONE;
            r_srcB  <= RNONE;
        end else if (!E_stall) begin
            r_stat  <= D_stat;
            r_icode <= D_icode;
            r_ifun  <= D_ifun;
            r_valC  <= D_valC;
            r_valA  <= w_valA;
            r_valB  <= w_valB;
            r_dstE  <= w_dstE;
            r_dstM  <= w_dstM;
            r_srcA  <= w_srcA;
            r_srcB  <= w_srcB;
        end
    end

    assign E_stat  = r_stat;
    assign E_icode = r_icode;
    assign E_ifun  = r_ifun;
    assign E_valC  = r_valC;
    assign E_valA  = r_valA;
    assign E_valB  = r_valB;
    assign E_dstE  = r_dstE;
    assign E_dstM  = r_dstM;
    assign E_srcA  = r_srcA;
    assign E_srcB  = r_srcB;

endmodule
